// File: rtl/uart_axis_fifo.sv
// ============================================================================
// Module   : uart_axis_fifo
// Brief    : First-word-fall-through AXI-Stream byte FIFO between the register
//            front end and the uart core. Optional level interrupt when
//            UART_FIFO_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_axis_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int IRQ_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  irq
);

    localparam int                c_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_PTR_ONE = (DEPTH_LOG2+1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DEPTH_LOG2:0]   r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_tready;
    logic [DEPTH_LOG2:0]   w_wr_next;
    logic [DEPTH_LOG2:0]   w_rd_next;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic                  w_full_next;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;

    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign empty         = w_empty;
    assign full          = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                           (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
    assign count         = r_count;
    assign s_axis_tready = r_tready;
    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    assign w_push = s_axis_tvalid && r_tready;
    assign w_pop  = !w_empty && m_axis_tready;

    // Flush collapses the read pointer onto the write pointer and wins over
    // any handshake in the same cycle.
    always_comb begin
        w_wr_next = r_wr_ptr;
        w_rd_next = r_rd_ptr;
        if (flush) begin
            w_rd_next = r_wr_ptr;
        end else begin
            if (w_push) w_wr_next = r_wr_ptr + c_PTR_ONE;
            if (w_pop)  w_rd_next = r_rd_ptr + c_PTR_ONE;
        end
    end

    assign w_count_next = w_wr_next - w_rd_next;
    assign w_full_next  = (w_wr_next[DEPTH_LOG2-1:0] == w_rd_next[DEPTH_LOG2-1:0]) &&
                          (w_wr_next[DEPTH_LOG2] != w_rd_next[DEPTH_LOG2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tready <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_tready <= !w_full_next;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !rst) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= s_axis_tdata;
        end
    end

`ifdef UART_FIFO_IRQ_EN
    localparam logic [DEPTH_LOG2:0] c_IRQ_THRESH = (DEPTH_LOG2+1)'(IRQ_THRESH);

    logic r_irq;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (w_count_next >= c_IRQ_THRESH);
        end
    end

    assign irq = r_irq;
`else
    // Threshold only folds into a constant here; no comparator remains.
    assign irq = 1'b0 && (IRQ_THRESH < 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_axis_fifo.sv
// ============================================================================
// Module   : tb_uart_axis_fifo
// Brief    : Self-checking bench for uart_axis_fifo (depth 4, threshold 3),
//            queue-based reference model plus directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_axis_fifo;

    localparam int DW     = 8;
    localparam int DL2    = 2;
    localparam int DEPTH  = 4;
    localparam int THRESH = 3;
`ifdef UART_FIFO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DL2:0]  count;
    logic          empty;
    logic          full;
    logic          irq;

    uart_axis_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL2),
        .IRQ_THRESH (THRESH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, ready/irq from the fill level.
    logic [DW-1:0] mdl_q[$];
    logic [DW-1:0] out_log[$];
    bit            mdl_rdy = 1'b0;
    bit            mdl_irq = 1'b0;
    bit            started = 1'b0;

    always @(posedge clk) begin
        bit do_push;
        bit do_pop;
        started = 1'b1;
        if (rst) begin
            mdl_q.delete();
            mdl_rdy = 1'b0;
            mdl_irq = 1'b0;
        end else if (flush) begin
            mdl_q.delete();
            mdl_rdy = 1'b1;
            mdl_irq = 1'b0;
        end else begin
            do_push = s_axis_tvalid && mdl_rdy;
            do_pop  = (mdl_q.size() > 0) && m_axis_tready;
            if (do_pop)  out_log.push_back(mdl_q.pop_front());
            if (do_push) mdl_q.push_back(s_axis_tdata);
            mdl_rdy = (mdl_q.size() < DEPTH);
            mdl_irq = IRQ_ON && (mdl_q.size() >= THRESH);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("count",  32'(count),         32'(mdl_q.size()));
            check("empty",  32'(empty),         32'(mdl_q.size() == 0));
            check("full",   32'(full),          32'(mdl_q.size() == DEPTH));
            check("tvalid", 32'(m_axis_tvalid), 32'(mdl_q.size() != 0));
            check("tready", 32'(s_axis_tready), 32'(mdl_rdy));
            check("irq",    32'(irq),           32'(mdl_irq));
            if (mdl_q.size() != 0) check("tdata", 32'(m_axis_tdata), 32'(mdl_q[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] exp_drain [6];
        int            idx;
        bit            acc;
        bit            ok;
        bit            seen_aa;

        exp_drain = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rst = 1'b1; flush = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;

        // Reset then idle
        tick(); tick();
        check("rst_tready", 32'(s_axis_tready), 32'h0);
        check("rst_empty",  32'(empty),         32'h1);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_tready", 32'(s_axis_tready), 32'h1);
        check("post_rst_count",  32'(count),         32'h0);

        // Fill to full with the consumer stalled
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 8'h11; tick();
        check("fill1_count", 32'(count), 32'h1);
        s_axis_tdata = 8'h22; tick();
        s_axis_tdata = 8'h33; tick();
        check("fill3_count", 32'(count), 32'h3);
        check("fill3_irq",   32'(irq),   32'(IRQ_ON));
        s_axis_tdata = 8'h44; tick();
        check("fill4_full",   32'(full),          32'h1);
        check("fill4_tready", 32'(s_axis_tready), 32'h0);
        s_axis_tdata = 8'h55; tick(); tick();
        check("held55_count", 32'(count),        32'h4);
        check("held55_head",  32'(m_axis_tdata), 32'h11);

        // Drain while refilling, pointers wrap
        m_axis_tready = 1'b1;
        idx = 0; ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            s_axis_tvalid = (idx < 2);
            s_axis_tdata  = (idx == 0) ? 8'h55 : 8'h66;
            acc = s_axis_tvalid && s_axis_tready;
            tick();
            if (acc) idx++;
            if (idx == 2 && empty) begin
                ok = 1'b1;
                break;
            end
        end
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        check("drain_done",  32'(ok),             32'h1);
        check("drain_len",   32'(out_log.size()), 32'h6);
        for (int i = 0; i < 6; i++)
            if (i < out_log.size()) check("drain_order", 32'(out_log[i]), 32'(exp_drain[i]));
        check("drain_irq",   32'(irq),   32'h0);
        check("drain_count", 32'(count), 32'h0);

        // Simultaneous push/pop at count 2
        out_log.delete();
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 8'h80; tick();
        s_axis_tdata = 8'h81; tick();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_axis_tdata = 8'(8'h82 + i);
            tick();
            check("pp_count", 32'(count), 32'h2);
        end
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        check("pp_len", 32'(out_log.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            if (i < out_log.size()) check("pp_order", 32'(out_log[i]), 32'(8'h80 + i));

        // Flush collision at count 3
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h8C; tick();
        check("pre_flush_count", 32'(count), 32'h3);
        out_log.delete();
        flush = 1'b1; s_axis_tdata = 8'hAA; m_axis_tready = 1'b1;
        tick();
        flush = 1'b0; s_axis_tvalid = 1'b0;
        check("flush_count",  32'(count),         32'h0);
        check("flush_empty",  32'(empty),         32'h1);
        check("flush_irq",    32'(irq),           32'h0);
        check("flush_tready", 32'(s_axis_tready), 32'h1);
        tick(); tick();
        seen_aa = 1'b0;
        foreach (out_log[i]) if (out_log[i] == 8'hAA) seen_aa = 1'b1;
        check("flush_no_aa", 32'(seen_aa), 32'h0);
        m_axis_tready = 1'b0;

        // Reset mid-stream
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 8'h31; tick();
        s_axis_tdata = 8'h32; tick();
        s_axis_tvalid = 1'b0;
        check("mid_count", 32'(count), 32'h2);
        rst = 1'b1; tick();
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'h0);
        rst = 1'b0; tick();
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h77; tick();
        s_axis_tvalid = 1'b0;
        check("mid_after_count", 32'(count),        32'h1);
        check("mid_after_head",  32'(m_axis_tdata), 32'h77);
        m_axis_tready = 1'b1; tick(); tick();
        check("final_empty", 32'(empty), 32'h1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
